// File: rtl/mux4_rr_sched_if.sv
// Request/grant bundle between the four requesters and the mux scheduler.
// The scheduler side owns gnt and the mux select lines.
interface mux4_rr_sched_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       busy;

    modport master (
        output req,
        input  gnt,
        input  s1,
        input  s0,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output s1,
        output s0,
        output busy
    );
endinterface

// File: rtl/mux4_rr_sched.sv
// Round-robin owner scheduler for a shared 4:1 mux with bounded hold time.
// Grant and select lines are registered; select keeps the last owner when idle.
module mux4_rr_sched #(
    parameter int MAX_HOLD = 8
) (
    input logic            clk,
    input logic            rst,
    mux4_rr_sched_if.slave bus
);

    localparam logic [7:0] HOLD = 8'(MAX_HOLD);

    typedef enum logic {IDLE, OWN} state_t;

    state_t     state;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [7:0] cnt;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;
    logic       busy_q;

    logic [3:0] others;
    logic [1:0] rot_ptr;
    logic [1:0] win;
    logic       take;
    logic       owner_req;
    logic       expired;

    function automatic logic [1:0] rr_pick(
        input logic [1:0] start,
        input logic [3:0] r
    );
        logic [1:0] idx;
        rr_pick = start;
        // Descending scan so the nearest index to start wins last.
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign others    = bus.req & ~(4'b0001 << owner);
    assign rot_ptr   = owner + 2'd1;
    assign owner_req = bus.req[owner];
    assign expired   = (cnt == HOLD);

    always_comb begin
        take = 1'b0;
        win  = rr_pick(ptr, bus.req);
        unique case (state)
            IDLE: take = |bus.req;
            OWN: begin
                if (!owner_req || expired) begin
                    win  = rr_pick(rot_ptr, others);
                    take = |others;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= 2'd0;
            ptr    <= 2'd0;
            cnt    <= 8'd0;
            gnt_q  <= 4'b0000;
            sel_q  <= 2'd0;
            busy_q <= 1'b0;
        end else begin
            if (take) begin
                state  <= OWN;
                owner  <= win;
                gnt_q  <= 4'b0001 << win;
                sel_q  <= win;
                busy_q <= 1'b1;
                cnt    <= 8'd1;
            end else if (state == OWN) begin
                if (!owner_req) begin
                    state  <= IDLE;
                    gnt_q  <= 4'b0000;
                    busy_q <= 1'b0;
                end else if (expired) begin
                    cnt <= 8'd1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
            // Pointer moves past the owner only when it actually gives up the mux.
            if (state == OWN && (!owner_req || (expired && |others)))
                ptr <= rot_ptr;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.s1   = sel_q[1];
    assign bus.s0   = sel_q[0];
    assign bus.busy = busy_q;

endmodule
